cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter FETCH_WAIT, default 1: instruction-memory read latency in cycles (legal 1..15).
REQ-002 Parameter MEM_WAIT, default 2: DRAM access cycles for opcodes 0111/1000 (legal 1..15).
REQ-003 Parameter STALL_LIMIT, default 1024: UART stall timeout in cycles (used only under STALL_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; leaves IDLE or HALT.
REQ-007 opcode  in  4  instruction[15:12] from the IR.
REQ-008 pc_jmp  in  1  jump-taken from the instruction decoder; sampled only in EXEC.
REQ-009 tx_busy  in  1  UART transmitter busy.
REQ-010 rx_ready  in  1  UART receive byte available.
REQ-011 iram_re  out  1  instruction-memory read enable.
REQ-012 ir_we  out  1  instruction-register load strobe.
REQ-013 exec_en  out  1  qualifies decoder control signals (register/AC/UART/DRAM writes).
REQ-014 dram_en  out  1  DRAM access window for memory opcodes.
REQ-015 pc_inc  out  1  program-counter increment strobe.
REQ-016 halted  out  1  high while in HALT.
REQ-017 state  out  3  current FSM state encoding.
REQ-018 instr_count  out  16  retired-instruction count.
REQ-019 stall_err  out  1  sticky UART-stall timeout flag.

Function
REQ-020 States and encodings SHALL be IDLE=0, FETCH=1, LOAD=2, DECODE=3, EXEC=4, MEMW=5, STALL=6, HALT=7; all outputs Moore-decoded from registered state except pc_inc.
REQ-021 IDLE: start=1 -> FETCH; otherwise remain.
REQ-022 FETCH: iram_re=1 for exactly FETCH_WAIT cycles (down-counter loaded on entry), then -> LOAD.
REQ-023 LOAD: ir_we=1 for one cycle -> DECODE.
REQ-024 DECODE (one cycle, priority order): opcode 0000 -> HALT; 0111 or 1000 -> MEMW; 1101 with tx_busy=1 -> STALL; 1110 with rx_ready=0 -> STALL; else -> EXEC.
REQ-025 MEMW: dram_en=1 for exactly MEM_WAIT cycles, then -> EXEC.
REQ-026 STALL: remain while the REQ-024 stall condition for the latched opcode holds; cycle after it clears -> EXEC.
REQ-027 EXEC: exec_en=1 for one cycle; pc_inc=~pc_jmp in the same cycle; instr_count increments; -> FETCH.
REQ-028 HALT: halted=1, pc_inc=0; start=1 -> FETCH with pc_inc=1 on the exit cycle (skips the halt word).
REQ-029 start SHALL be ignored in every state other than IDLE and HALT.
REQ-030 instr_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-031 Worst-case non-stalled instruction: FETCH_WAIT+3 cycles; memory opcode FETCH_WAIT+MEM_WAIT+3 cycles.
REQ-032 At most one of iram_re, ir_we, exec_en, dram_en SHALL be high in any cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, all wait/stall counters=0, instr_count=0, stall_err=0, all strobes=0, halted=0, including mid-FETCH/MEMW/STALL.
REQ-034 After rst_n release, first FETCH SHALL occur only on a sampled start=1.

Configuration
REQ-035 Macro STALL_TIMEOUT_EN defined: STALL counts cycles; on reaching STALL_LIMIT consecutive cycles, stall_err set (sticky until reset) and -> HALT without exec_en or pc_inc.
REQ-036 Macro undefined: no timeout counter; stall_err tied 0; STALL waits indefinitely.

Verification
REQ-037 Reset, start=1 one cycle, opcode=0001, defaults -> iram_re 1 cycle, ir_we, DECODE, exec_en+pc_inc at cycle 4 after start, instr_count=1.
REQ-038 opcode=1000, MEM_WAIT=2 -> dram_en high exactly 2 cycles, then exec_en; total 6 cycles per instruction.
REQ-039 opcode=1101, tx_busy=1 for 10 cycles -> state=6 for 10 cycles, exec_en 1 cycle after tx_busy falls; opcode=1110 with rx_ready=0 likewise.
REQ-040 opcode=1001 with pc_jmp=1 in EXEC -> exec_en=1, pc_inc=0; opcode=0000 -> halted=1, start -> pc_inc=1 and FETCH.
REQ-041 rst_n pulsed low mid-MEMW -> state=0, dram_en=0 same cycle; instr_count preloaded to 0xFFFF then one EXEC -> 0x0000.
REQ-042 STALL_TIMEOUT_EN, STALL_LIMIT=8, rx_ready held 0 on opcode 1110 -> stall_err=1 and halted=1 after 8 stall cycles; undefined -> still STALL at cycle 100.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Bundles the control handshake between the instruction sequencer and the
//   datapath / UART / memory blocks it paces.
//   master : the sequencer (samples decoder/UART status, drives strobes)
//   slave  : the datapath side (drives status, samples strobes)
//   Signals
//     start        level request to leave IDLE or HALT
//     opcode[3:0]  instruction[15:12] from the IR
//     pc_jmp       jump-taken from the decoder, used only in EXEC
//     tx_busy      UART transmitter busy
//     rx_ready     UART receive byte available
//     iram_re      instruction-memory read enable
//     ir_we        instruction-register load strobe
//     exec_en      qualifies decoder write controls
//     dram_en      DRAM access window
//     pc_inc       program-counter increment strobe
//     halted       high while in HALT
//     state[2:0]   current sequencer state encoding
//     instr_count  retired-instruction count (wraps)
//     stall_err    sticky UART stall timeout flag
interface cpu_sequencer_if;
  logic        start;
  logic [3:0]  opcode;
  logic        pc_jmp;
  logic        tx_busy;
  logic        rx_ready;
  logic        iram_re;
  logic        ir_we;
  logic        exec_en;
  logic        dram_en;
  logic        pc_inc;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic        stall_err;

  modport master (
    input  start, opcode, pc_jmp, tx_busy, rx_ready,
    output iram_re, ir_we, exec_en, dram_en, pc_inc, halted, state,
           instr_count, stall_err
  );

  modport slave (
    output start, opcode, pc_jmp, tx_busy, rx_ready,
    input  iram_re, ir_we, exec_en, dram_en, pc_inc, halted, state,
           instr_count, stall_err
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle instruction sequencer: fetch, IR load, decode, optional DRAM
//   wait or UART stall, execute. Strobes are Moore-decoded from the state
//   register; only pc_inc looks at live inputs (pc_jmp in EXEC, start in HALT).
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    cpu_sequencer_if.master (status in, strobes/state/count out)
//   Parameters
//     FETCH_WAIT   instruction-memory latency in cycles (1..15)
//     MEM_WAIT     DRAM access cycles for opcodes 0111/1000 (1..15)
//     STALL_LIMIT  UART stall timeout in cycles
//   Build option
//     STALL_TIMEOUT_EN  when defined, a stall lasting STALL_LIMIT cycles sets
//                       the sticky stall_err and parks the sequencer in HALT.
//                       When undefined, STALL waits forever and stall_err = 0.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | after reset, waits for start
//   FETCH  | iram_re for FETCH_WAIT cycles
//   LOAD   | ir_we for one cycle
//   DECODE | classify opcode, latch it for the stall check
//   EXEC   | exec_en one cycle, pc_inc unless jump taken, count retires
//   MEMW   | dram_en for MEM_WAIT cycles
//   STALL  | waits for UART tx idle / rx byte
//   HALT   | halted; start resumes at FETCH skipping the halt word
module cpu_sequencer #(
  parameter int FETCH_WAIT  = 1,
  parameter int MEM_WAIT    = 2,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    MEMW   = 3'd5,
    STALL  = 3'd6,
    HALT   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] instr_count_q;

  function automatic logic stall_hit(input logic [3:0] op, input logic tx_busy,
                                     input logic rx_ready);
    return ((op == 4'b1101) && tx_busy) || ((op == 4'b1110) && !rx_ready);
  endfunction

`ifdef STALL_TIMEOUT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          stall_err_q, stall_err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      op_q          <= '0;
      instr_count_q <= '0;
`ifdef STALL_TIMEOUT_EN
      stall_q       <= '0;
      stall_err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      if (state_q == EXEC) instr_count_q <= instr_count_q + 16'd1;
`ifdef STALL_TIMEOUT_EN
      stall_q     <= stall_d;
      stall_err_q <= stall_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
`ifdef STALL_TIMEOUT_EN
    stall_d     = stall_q;
    stall_err_d = stall_err_q;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d = FETCH;
          wait_d  = 4'(FETCH_WAIT - 1);
        end
      end
      FETCH: begin
        if (wait_q == 4'd0) state_d = LOAD;
        else                wait_d  = wait_q - 4'd1;
      end
      LOAD: state_d = DECODE;
      DECODE: begin
        op_d = bus.opcode;
        if (bus.opcode == 4'b0000) begin
          state_d = HALT;
        end else if (bus.opcode == 4'b0111 || bus.opcode == 4'b1000) begin
          state_d = MEMW;
          wait_d  = 4'(MEM_WAIT - 1);
        end else if (stall_hit(bus.opcode, bus.tx_busy, bus.rx_ready)) begin
          state_d = STALL;
`ifdef STALL_TIMEOUT_EN
          stall_d = SW'(STALL_LIMIT - 1);
`endif
        end else begin
          state_d = EXEC;
        end
      end
      MEMW: begin
        if (wait_q == 4'd0) state_d = EXEC;
        else                wait_d  = wait_q - 4'd1;
      end
      STALL: begin
        if (!stall_hit(op_q, bus.tx_busy, bus.rx_ready)) begin
          state_d = EXEC;
        end
`ifdef STALL_TIMEOUT_EN
        // Timed out: abandon the instruction without executing it.
        else if (stall_q == '0) begin
          state_d     = HALT;
          stall_err_d = 1'b1;
        end else begin
          stall_d = stall_q - 1'b1;
        end
`endif
      end
      EXEC: begin
        state_d = FETCH;
        wait_d  = 4'(FETCH_WAIT - 1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.iram_re     = (state_q == FETCH);
  assign bus.ir_we       = (state_q == LOAD);
  assign bus.exec_en     = (state_q == EXEC);
  assign bus.dram_en     = (state_q == MEMW);
  assign bus.halted      = (state_q == HALT);
  assign bus.instr_count = instr_count_q;
  // Leaving HALT increments past the halt word.
  assign bus.pc_inc      = ((state_q == EXEC) && !bus.pc_jmp) ||
                           ((state_q == HALT) && bus.start);
`ifdef STALL_TIMEOUT_EN
  assign bus.stall_err   = stall_err_q;
`else
  assign bus.stall_err   = 1'b0;
`endif

endmodule
